// File: rtl/edge_pattern_generator_pkg.sv
// -----------------------------------------------------------------------------
// edge_gen_pkg
// Shared types and constants for the edge pattern generator.
//   state_t      : control FSM encoding
//   MIN_SEG_LEN  : shortest segment in cycles; a programmed 0 is raised to this
// -----------------------------------------------------------------------------
package edge_gen_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        SEG1  = 3'd2,
        SEG2  = 3'd3,
        SEG3  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int unsigned MIN_SEG_LEN = 32'd1;

endpackage

// File: rtl/edge_pattern_generator_if.sv
// -----------------------------------------------------------------------------
// edge_pattern_generator_if
// Control, configuration and status bundle of the edge pattern generator.
//   slave  : the generator (consumes enable/trigger/config, drives status)
//   master : the regmap / peer block / bench that configures it
// -----------------------------------------------------------------------------
interface edge_pattern_generator_if #(
    parameter int CNT_W = 32,
    parameter int RPT_W = 16
);
    logic             enable;
    logic             trig_enable;
    logic             trig_in;
    logic             trig_out;
    logic             cfg_trig_out;
    logic             cfg_out_inv;
    logic [CNT_W-1:0] d1_len;
    logic [CNT_W-1:0] d2_len;
    logic [CNT_W-1:0] d3_len;
    logic [RPT_W-1:0] repeat_cnt;
    logic             gpio_out;
    logic             busy;
    logic             done;
    logic [RPT_W-1:0] burst_num;

    modport slave (
        input  enable, trig_enable, trig_in, cfg_trig_out, cfg_out_inv,
        input  d1_len, d2_len, d3_len, repeat_cnt,
        output trig_out, gpio_out, busy, done, burst_num
    );

    modport master (
        output enable, trig_enable, trig_in, cfg_trig_out, cfg_out_inv,
        output d1_len, d2_len, d3_len, repeat_cnt,
        input  trig_out, gpio_out, busy, done, burst_num
    );
endinterface

// File: rtl/edge_pattern_generator_seg_timer.sv
// -----------------------------------------------------------------------------
// seg_timer
// Segment down-counter. A load pulse arms it with len; expire is high on the
// last cycle of the segment, so a segment lasts max(len,1) cycles after load.
//   clk, rst_sync : clock, synchronous active-high reset
//   load          : start a new segment next cycle
//   len           : segment length in cycles (0 treated as 1)
//   expire        : current cycle is the final cycle of the segment
// -----------------------------------------------------------------------------
module seg_timer
    import edge_gen_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_sync,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load len-1 (clamped at 0), else count down to 0 and rest there.
    // Loading len-1 rather than len keeps an all-ones length from wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            if (len >= CNT_W'(MIN_SEG_LEN)) begin
                cnt_d = len - CNT_W'(MIN_SEG_LEN);
            end else begin
                cnt_d = '0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);
endmodule

// File: rtl/edge_pattern_generator.sv
// -----------------------------------------------------------------------------
// edge_pattern_generator
// Drives one GPIO with a burst of three timed segments (d1, d2, d3 cycles),
// toggling at the start of SEG2, the start of SEG3 and after SEG3, repeated
// repeat_cnt extra times. Config is shadowed at the enable rise.
//   clk, rst_sync : clock, synchronous active-high reset
//   bus (slave)   : enable, trig_enable, trig_in, cfg_trig_out, cfg_out_inv,
//                   d1_len..d3_len, repeat_cnt in; gpio_out, trig_out, busy,
//                   done, burst_num out (all registered)
// -----------------------------------------------------------------------------
module edge_pattern_generator
    import edge_gen_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int RPT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_sync,
    edge_pattern_generator_if.slave  bus
);
    state_t           state_q, state_d;
    logic             en_prev_q, en_prev_d;
    logic             gpio_q, gpio_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RPT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             ctrig_q, ctrig_d;
    logic             seg_load_s;
    logic [CNT_W-1:0] seg_len_s;
    logic             seg_expire_s;
    logic             start_s;

    seg_timer #(.CNT_W(CNT_W)) u_seg_timer (
        .clk      (clk),
        .rst_sync (rst_sync),
        .load     (seg_load_s),
        .len      (seg_len_s),
        .expire   (seg_expire_s)
    );

    // Because en_prev_q clears in reset, enable held high through reset counts as a rise.
    assign start_s   = bus.enable & ~en_prev_q;
    assign en_prev_d = bus.enable;

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        gpio_d     = gpio_q;
        trig_d     = 1'b0;
        burst_d    = burst_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        d3_d       = d3_q;
        rpt_d      = rpt_q;
        ctrig_d    = ctrig_q;
        seg_load_s = 1'b0;
        seg_len_s  = d1_q;
        case (state_q)
            IDLE: begin
                gpio_d = bus.cfg_out_inv;
                if (start_s) begin
                    d1_d    = bus.d1_len;
                    d2_d    = bus.d2_len;
                    d3_d    = bus.d3_len;
                    rpt_d   = bus.repeat_cnt;
                    ctrig_d = bus.cfg_trig_out;
                    burst_d = '0;
                    if (bus.trig_enable) begin
                        state_d = ARMED;
                    end else begin
                        state_d    = SEG1;
                        seg_load_s = 1'b1;
                        seg_len_s  = bus.d1_len;
                        trig_d     = ~bus.cfg_trig_out;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    gpio_d  = bus.cfg_out_inv;
                end else if (bus.trig_in) begin
                    state_d    = SEG1;
                    seg_load_s = 1'b1;
                    seg_len_s  = d1_q;
                    trig_d     = ~ctrig_q;
                end else begin
                    state_d = ARMED;
                end
            end
            SEG1: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    gpio_d  = bus.cfg_out_inv;
                end else if (seg_expire_s) begin
                    state_d    = SEG2;
                    seg_load_s = 1'b1;
                    seg_len_s  = d2_q;
                    gpio_d     = ~gpio_q;
                    trig_d     = ctrig_q & (burst_q == '0);
                end else begin
                    state_d = SEG1;
                end
            end
            SEG2: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    gpio_d  = bus.cfg_out_inv;
                end else if (seg_expire_s) begin
                    state_d    = SEG3;
                    seg_load_s = 1'b1;
                    seg_len_s  = d3_q;
                    gpio_d     = ~gpio_q;
                end else begin
                    state_d = SEG2;
                end
            end
            SEG3: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    gpio_d  = bus.cfg_out_inv;
                end else if (seg_expire_s) begin
                    gpio_d = ~gpio_q;
                    // Back-to-back bursts: the third edge is also the start of the next SEG1.
                    if (burst_q < rpt_q) begin
                        state_d    = SEG1;
                        burst_d    = burst_q + RPT_W'(1);
                        seg_load_s = 1'b1;
                        seg_len_s  = d1_q;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = SEG3;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    gpio_d  = bus.cfg_out_inv;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                gpio_d  = bus.cfg_out_inv;
            end
        endcase
        busy_d = (state_d == ARMED) || (state_d == SEG1) ||
                 (state_d == SEG2)  || (state_d == SEG3);
        done_d = (state_d == DONE);
    end

    // State, output and shadow registers.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q   <= IDLE;
            en_prev_q <= 1'b0;
            gpio_q    <= 1'b0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            burst_q   <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            rpt_q     <= '0;
            ctrig_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= en_prev_d;
            gpio_q    <= gpio_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            burst_q   <= burst_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            rpt_q     <= rpt_d;
            ctrig_q   <= ctrig_d;
        end
    end

    assign bus.gpio_out  = gpio_q;
    assign bus.trig_out  = trig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.burst_num = burst_q;
endmodule

// File: tb/tb_edge_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_edge_pattern_generator
// Directed bench: a table of burst configurations with hand-derived 16-cycle
// waveforms (bit j = cycle T+1+j after the enable rise), plus sequences for
// triggered start, abort/restart and reset in the middle of SEG3.
// -----------------------------------------------------------------------------
module tb_edge_pattern_generator;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [15:0] rpt;
        logic        inv;
        logic        ctrig;
        logic [15:0] exp_gpio;
        logic [15:0] exp_trig;
        logic [15:0] exp_done;
        logic [15:0] exp_busy;
        logic [15:0] exp_burst;
    } vec_t;

    logic clk = 1'b0;
    logic rst_sync;
    int   n_checks = 0;
    int   n_pass = 0;

    vec_t        vecs[5];
    logic [15:0] g, t, dn, bz;
    int          act_n, busy_n;

    edge_pattern_generator_if #(.CNT_W(32), .RPT_W(16)) bus ();

    edge_pattern_generator #(.CNT_W(32), .RPT_W(16)) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                           input logic [15:0] rpt, input logic inv, input logic ctrig,
                           input logic ten);
        bus.d1_len       = d1;
        bus.d2_len       = d2;
        bus.d3_len       = d3;
        bus.repeat_cnt   = rpt;
        bus.cfg_out_inv  = inv;
        bus.cfg_trig_out = ctrig;
        bus.trig_enable  = ten;
    endtask

    initial begin
        // d1, d2, d3, rpt, inv, ctrig, gpio, trig, done, busy, burst
        vecs[0] = '{32'd3, 32'd5, 32'd2, 16'd0, 1'b0, 1'b0, 16'hFCF8, 16'h0001, 16'hFC00, 16'h03FF, 16'd0};
        vecs[1] = '{32'd1, 32'd1, 32'd1, 16'd2, 1'b1, 1'b0, 16'h0155, 16'h0001, 16'hFE00, 16'h01FF, 16'd2};
        vecs[2] = '{32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b1, 16'hFFFA, 16'h0002, 16'hFFF8, 16'h0007, 16'd0};
        vecs[3] = '{32'd1, 32'd1, 32'd1, 16'd0, 1'b0, 1'b1, 16'hFFFA, 16'h0002, 16'hFFF8, 16'h0007, 16'd0};
        vecs[4] = '{32'd2, 32'd1, 32'd4, 16'd1, 1'b0, 1'b1, 16'h3D84, 16'h0004, 16'hC000, 16'h3FFF, 16'd1};

        rst_sync    = 1'b1;
        bus.enable  = 1'b0;
        bus.trig_in = 1'b0;
        set_cfg(32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gpio",  {31'd0, bus.gpio_out}, 32'd0);
        chk("reset_trig",  {31'd0, bus.trig_out}, 32'd0);
        chk("reset_busy",  {31'd0, bus.busy},     32'd0);
        chk("reset_done",  {31'd0, bus.done},     32'd0);
        chk("reset_burst", {16'd0, bus.burst_num}, 32'd0);
        @(negedge clk);
        rst_sync = 1'b0;

        // Table of full bursts; config is scrambled right after start to prove shadowing.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            bus.enable = 1'b0;
            set_cfg(vecs[v].d1, vecs[v].d2, vecs[v].d3, vecs[v].rpt, vecs[v].inv, vecs[v].ctrig, 1'b0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_idle_gpio", v), {31'd0, bus.gpio_out}, {31'd0, vecs[v].inv});
            bus.enable = 1'b1;
            for (int j = 0; j < 16; j++) begin
                @(posedge clk);
                #1;
                g[j]  = bus.gpio_out;
                t[j]  = bus.trig_out;
                dn[j] = bus.done;
                bz[j] = bus.busy;
                if (j == 0) begin
                    set_cfg(32'd7, 32'd9, 32'd6, 16'd5, ~vecs[v].inv, ~vecs[v].ctrig, 1'b1);
                end
            end
            chk($sformatf("v%0d_gpio", v),  {16'd0, g},  {16'd0, vecs[v].exp_gpio});
            chk($sformatf("v%0d_trig", v),  {16'd0, t},  {16'd0, vecs[v].exp_trig});
            chk($sformatf("v%0d_done", v),  {16'd0, dn}, {16'd0, vecs[v].exp_done});
            chk($sformatf("v%0d_busy", v),  {16'd0, bz}, {16'd0, vecs[v].exp_busy});
            chk($sformatf("v%0d_burst", v), {16'd0, bus.burst_num}, {16'd0, vecs[v].exp_burst});
            bus.enable = 1'b0;
        end

        // Triggered start: ARMED for 10 cycles, then trig_in; trig_out lands with edge 1.
        @(negedge clk);
        bus.enable = 1'b0;
        set_cfg(32'd3, 32'd2, 32'd2, 16'd0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        act_n  = 0;
        busy_n = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            if (bus.gpio_out || bus.trig_out || bus.done) act_n++;
            if (bus.busy) busy_n++;
        end
        chk("armed_no_activity", act_n,  32'd0);
        chk("armed_busy_cycles", busy_n, 32'd10);
        @(negedge clk);
        bus.trig_in = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            if (j == 0) bus.trig_in = 1'b0;
            g[j] = bus.gpio_out;
            t[j] = bus.trig_out;
        end
        chk("trig_start_gpio", {24'd0, g[7:0]}, 32'h98);
        chk("trig_start_trig", {24'd0, t[7:0]}, 32'h08);
        bus.enable = 1'b0;

        // Abort in SEG2 of burst 2, then restart from burst 0.
        @(negedge clk);
        set_cfg(32'd1, 32'd3, 32'd1, 16'd2, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("pre_abort_burst", {16'd0, bus.burst_num}, 32'd2);
        chk("pre_abort_gpio",  {31'd0, bus.gpio_out},  32'd0);
        chk("pre_abort_busy",  {31'd0, bus.busy},      32'd1);
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_gpio",  {31'd0, bus.gpio_out},  32'd1);
        chk("abort_busy",  {31'd0, bus.busy},      32'd0);
        chk("abort_done",  {31'd0, bus.done},      32'd0);
        chk("abort_burst", {16'd0, bus.burst_num}, 32'd2);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_burst", {16'd0, bus.burst_num}, 32'd0);
        chk("restart_trig",  {31'd0, bus.trig_out},  32'd1);
        chk("restart_busy",  {31'd0, bus.busy},      32'd1);
        chk("restart_gpio",  {31'd0, bus.gpio_out},  32'd1);
        bus.enable = 1'b0;

        // Reset during SEG3; enable stays high so a new start follows reset release.
        @(negedge clk);
        set_cfg(32'd1, 32'd1, 32'd5, 16'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("seg3_gpio", {31'd0, bus.gpio_out}, 32'd1);
        chk("seg3_busy", {31'd0, bus.busy},     32'd1);
        rst_sync = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_gpio",  {31'd0, bus.gpio_out},  32'd0);
        chk("midrst_busy",  {31'd0, bus.busy},      32'd0);
        chk("midrst_done",  {31'd0, bus.done},      32'd0);
        chk("midrst_trig",  {31'd0, bus.trig_out},  32'd0);
        chk("midrst_burst", {16'd0, bus.burst_num}, 32'd0);
        rst_sync = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_busy", {31'd0, bus.busy},     32'd1);
        chk("postrst_trig", {31'd0, bus.trig_out}, 32'd1);
        chk("postrst_gpio", {31'd0, bus.gpio_out}, 32'd1);
        bus.enable = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
